// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, condition function codes,
// register sentinel and condition-code layout.
package y86_pkg;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/cond_eval.sv
// Branch / conditional-move condition evaluator over the {ZF,SF,OF} flags.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic sf;
    logic of;
    logic lt;

    assign zf = cc[CC_ZF];
    assign sf = cc[CC_SF];
    assign of = cc[CC_OF];
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute-stage back end: condition-code register, condition evaluation and
// the E->M pipeline register with stall/bubble control.
module exec_cc_stage
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         e_valid,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [W-1:0] alu_out,
    input  logic [2:0]   alu_cc,
    input  logic [W-1:0] e_valA,
    input  logic [3:0]   e_dstE,
    input  logic [3:0]   e_dstM,
    input  logic         set_cc_en,
    input  logic         m_stall,
    input  logic         m_bubble,
    output logic [2:0]   cc_q,
    output logic         e_cnd,
    output logic         M_valid,
    output logic         M_cnd,
    output logic [3:0]   M_icode,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    logic       cond_raw;
    logic       uses_cnd;
    logic [3:0] dst_e_eff;
    logic       cc_write;

    // Flags come from the registered CC only, so the ALU never reaches an output.
    cond_eval u_cond_eval (
        .cc   (cc_q),
        .ifun (e_ifun),
        .cnd  (cond_raw)
    );

    assign uses_cnd  = (e_icode == I_CMOVXX) || (e_icode == I_JXX);
    assign e_cnd     = uses_cnd & cond_raw;
    assign dst_e_eff = ((e_icode == I_CMOVXX) && !e_cnd) ? RNONE : e_dstE;
    assign cc_write  = e_valid && (e_icode == I_OPQ) && set_cc_en && !m_stall && !m_bubble;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= CC_RESET;
        end else if (cc_write) begin
            cc_q <= alu_cc;
        end
    end

    // Priority: reset > bubble > stall > load.
    always_ff @(posedge clk) begin
        if (!rst_n || m_bubble || (!m_stall && !e_valid)) begin
            M_valid <= 1'b0;
            M_cnd   <= 1'b0;
            M_icode <= I_NOP;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!m_stall) begin
            M_valid <= 1'b1;
            M_cnd   <= e_cnd;
            M_icode <= e_icode;
            M_valE  <= alu_out;
            M_valA  <= e_valA;
            M_dstE  <= dst_e_eff;
            M_dstM  <= e_dstM;
        end
    end

endmodule

// File: tb/tb_exec_cc_stage.sv
// Randomised + directed self-checking bench for exec_cc_stage against a
// flag-level reference model of the execute back end.
module tb_exec_cc_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         e_valid;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] alu_out;
    logic [2:0]   alu_cc;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         set_cc_en;
    logic         m_stall;
    logic         m_bubble;
    logic [2:0]   cc_q;
    logic         e_cnd;
    logic         M_valid;
    logic         M_cnd;
    logic [3:0]   M_icode;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit           r_zf, r_sf, r_of;
    bit           r_valid, r_cnd;
    bit [3:0]     r_icode, r_dstE, r_dstM;
    bit [W-1:0]   r_valE, r_valA;

    always #5 clk = ~clk;

    exec_cc_stage #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode),
        .e_ifun(e_ifun), .alu_out(alu_out), .alu_cc(alu_cc), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM), .set_cc_en(set_cc_en),
        .m_stall(m_stall), .m_bubble(m_bubble), .cc_q(cc_q), .e_cnd(e_cnd),
        .M_valid(M_valid), .M_cnd(M_cnd), .M_icode(M_icode), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Condition semantics in terms of "signed less-than" and "equal".
    function automatic bit ref_cond(input int f);
        bit less  = (r_sf != r_of);
        bit equal = r_zf;
        case (f)
            0: return 1'b1;
            1: return less || equal;
            2: return less;
            3: return equal;
            4: return !equal;
            5: return !less;
            6: return !less && !equal;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void ref_nop();
        r_valid = 0; r_cnd = 0; r_icode = 4'h1;
        r_valE = '0; r_valA = '0; r_dstE = 4'hF; r_dstM = 4'hF;
    endfunction

    task automatic step(input bit rn, input bit v, input bit [3:0] ic, input bit [3:0] fn,
                        input bit [W-1:0] ao, input bit [2:0] ac, input bit [W-1:0] va,
                        input bit [3:0] de, input bit [3:0] dm, input bit sce,
                        input bit st, input bit bu);
        bit cnd_exp;
        @(negedge clk);
        rst_n = rn; e_valid = v; e_icode = ic; e_ifun = fn; alu_out = ao; alu_cc = ac;
        e_valA = va; e_dstE = de; e_dstM = dm; set_cc_en = sce; m_stall = st; m_bubble = bu;
        #1;
        cnd_exp = ((ic == 4'd2) || (ic == 4'd7)) ? ref_cond(int'(fn)) : 1'b0;
        check_val("e_cnd", e_cnd, cnd_exp);
        if (!rn) begin
            {r_zf, r_sf, r_of} = 3'b100;
            ref_nop();
        end else if (bu) begin
            ref_nop();
        end else if (!st) begin
            if (v && ic == 4'd6 && sce) {r_zf, r_sf, r_of} = ac;
            if (v) begin
                r_valid = 1; r_cnd = cnd_exp; r_icode = ic; r_valE = ao; r_valA = va;
                r_dstE = (ic == 4'd2 && !cnd_exp) ? 4'hF : de;
                r_dstM = dm;
            end else begin
                ref_nop();
            end
        end
        @(posedge clk);
        #1;
        check_val("cc_q", cc_q, {r_zf, r_sf, r_of});
        check_val("M_valid", M_valid, r_valid);
        check_val("M_cnd", M_cnd, r_cnd);
        check_val("M_icode", M_icode, r_icode);
        check_val("M_valE", M_valE, r_valE);
        check_val("M_valA", M_valA, r_valA);
        check_val("M_dstE", M_dstE, r_dstE);
        check_val("M_dstM", M_dstM, r_dstM);
        $display("cyc rst_n=%0b v=%0b ic=%0h fn=%0h st=%0b bu=%0b -> cc=%03b M_valid=%0b M_icode=%0h M_dstE=%0h",
                 rn, v, ic, fn, st, bu, cc_q, M_valid, M_icode, M_dstE);
    endtask

    initial begin
        bit [3:0] ic;
        bit [3:0] icodes [5];
        icodes = '{4'd1, 4'd2, 4'd6, 4'd7, 4'd0};
        {r_zf, r_sf, r_of} = 3'b100;
        ref_nop();

        // Reset, then OPq producing zero, then je / jne
        step(0, 1, 4'd6, 4'd0, 64'h55, 3'b011, 64'h1, 4'd3, 4'd4, 1, 0, 0);
        step(1, 1, 4'd6, 4'd1, 64'h0,  3'b100, 64'h7, 4'd2, 4'hF, 1, 0, 0);
        step(1, 1, 4'd7, 4'd3, 64'h10, 3'b000, 64'h0, 4'hF, 4'hF, 1, 0, 0);
        step(1, 1, 4'd7, 4'd4, 64'h10, 3'b000, 64'h0, 4'hF, 4'hF, 1, 0, 0);
        // cmovl not taken with 000, taken with 010
        step(1, 1, 4'd6, 4'd0, 64'h1,  3'b000, 64'h0, 4'd1, 4'hF, 1, 0, 0);
        step(1, 1, 4'd2, 4'd2, 64'h9,  3'b111, 64'h9, 4'd3, 4'hF, 1, 0, 0);
        step(1, 1, 4'd6, 4'd0, 64'h1,  3'b010, 64'h0, 4'd1, 4'hF, 1, 0, 0);
        step(1, 1, 4'd2, 4'd2, 64'h9,  3'b000, 64'h9, 4'd3, 4'hF, 1, 0, 0);
        // Gating: set_cc_en low, then stalled, then released
        step(1, 1, 4'd6, 4'd0, 64'hA,  3'b011, 64'h0, 4'd1, 4'hF, 0, 0, 0);
        step(1, 1, 4'd6, 4'd0, 64'hB,  3'b011, 64'h0, 4'd1, 4'hF, 1, 1, 0);
        step(1, 1, 4'd6, 4'd0, 64'hC,  3'b011, 64'h0, 4'd1, 4'hF, 1, 0, 0);
        // Overflow compare with cc=011: jg, jl, ifun 9
        step(1, 1, 4'd7, 4'd6, 64'h0,  3'b000, 64'h0, 4'hF, 4'hF, 1, 0, 0);
        step(1, 1, 4'd7, 4'd2, 64'h0,  3'b000, 64'h0, 4'hF, 4'hF, 1, 0, 0);
        step(1, 1, 4'd7, 4'd9, 64'h0,  3'b000, 64'h0, 4'hF, 4'hF, 1, 0, 0);
        // Stall+bubble together, then invalid load, then reset while stalled
        step(1, 1, 4'd6, 4'd0, 64'h77, 3'b100, 64'h5, 4'd2, 4'd6, 1, 1, 1);
        step(1, 0, 4'd6, 4'd0, 64'h77, 3'b100, 64'h5, 4'd2, 4'd6, 1, 0, 0);
        step(1, 1, 4'd6, 4'd0, 64'h78, 3'b010, 64'h5, 4'd2, 4'd6, 1, 0, 0);
        step(0, 1, 4'd6, 4'd0, 64'h79, 3'b001, 64'h5, 4'd2, 4'd6, 1, 1, 0);

        for (int n = 0; n < 400; n++) begin
            ic = ($urandom_range(0, 4) == 0) ? 4'($urandom) : icodes[$urandom_range(0, 4)];
            step($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 85, ic,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6)),
                 {$urandom, $urandom}, 3'($urandom), {$urandom, $urandom},
                 4'($urandom), 4'($urandom), $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
